// File: rtl/amp_power_sequencer_if.sv
// ---------------------------------------------------------------------------
// amp_power_sequencer_if
// Write-request channel between the amplifier power sequencer and the
// amp-side I2C master.
//   i2c_req  : write request, held until i2c_done
//   i2c_dev  : 7-bit I2C device address
//   i2c_reg  : amp register address, stable while i2c_req=1
//   i2c_dat  : amp register data, stable while i2c_req=1
//   i2c_done : 1-cycle pulse, transaction finished
//   i2c_nack : valid with i2c_done, 1 = slave NACKed
// master = sequencer side, slave = I2C master side.
// ---------------------------------------------------------------------------
interface amp_power_sequencer_if;
  logic       i2c_req;
  logic [6:0] i2c_dev;
  logic [7:0] i2c_reg;
  logic [7:0] i2c_dat;
  logic       i2c_done;
  logic       i2c_nack;

  modport master (
    output i2c_req, i2c_dev, i2c_reg, i2c_dat,
    input  i2c_done, i2c_nack
  );

  modport slave (
    input  i2c_req, i2c_dev, i2c_reg, i2c_dat,
    output i2c_done, i2c_nack
  );
endinterface

// File: rtl/amp_power_sequencer.sv
// ---------------------------------------------------------------------------
// amp_power_sequencer
// Power-up / shutdown sequencer for the external class-D amplifier. Enables
// the amp, waits for it to settle, replays a register table from an external
// combinational ROM through the I2C master, then unmutes. Shutdown mutes,
// waits, then disables. Repeated NACKs on one entry land in FAULT.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   ena                 : 1 = run amp, 0 = shut down (level)
//   soft_mute           : mute request, honoured in RUN only
//   tbl_idx/reg/val     : table ROM index out, register address/value in
//   i2c (master)        : write request channel to the amp I2C master
//   amp_nenable         : amp enable, active low
//   amp_nmute           : amp mute, active low
//   seq_ready/seq_fault : in RUN / in FAULT
//   seq_state           : state code for debug
// All outputs are registered.
// ---------------------------------------------------------------------------
module amp_power_sequencer #(
  parameter logic [6:0] DEV_ADDR     = 7'h2C,
  parameter int         N_REGS       = 8,
  parameter int         T_EN_CYC     = 1024,
  parameter int         T_UNMUTE_CYC = 512,
  parameter int         RETRIES      = 2,
  localparam int        IW           = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic                  soft_mute,
  output logic [IW-1:0]         tbl_idx,
  input  logic [7:0]            tbl_reg,
  input  logic [7:0]            tbl_val,
  amp_power_sequencer_if.master i2c,
  output logic                  amp_nenable,
  output logic                  amp_nmute,
  output logic                  seq_ready,
  output logic                  seq_fault,
  output logic [2:0]            seq_state
);

  localparam int T_MAX = (T_EN_CYC > T_UNMUTE_CYC) ? T_EN_CYC : T_UNMUTE_CYC;
  localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int RW    = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

  localparam logic [CW-1:0] EN_LOAD  = CW'(T_EN_CYC - 1);
  localparam logic [CW-1:0] UM_LOAD  = CW'(T_UNMUTE_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REGS - 1);
  localparam logic [RW-1:0] MAX_RTY  = RW'(RETRIES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PWRUP  = 3'd1,
    WRITE  = 3'd2,
    GAP    = 3'd3,
    UNMUTE = 3'd4,
    RUN    = 3'd5,
    SHDN   = 3'd6,
    FAULT  = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [RW-1:0] rty_q, rty_d;
  logic          req_q, req_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    dat_q, dat_d;
  logic          nen_q, nen_d;
  logic          nmute_q, nmute_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rty_q   <= '0;
      req_q   <= 1'b0;
      reg_q   <= '0;
      dat_q   <= '0;
      nen_q   <= 1'b1;
      nmute_q <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rty_q   <= rty_d;
      req_q   <= req_d;
      reg_q   <= reg_d;
      dat_q   <= dat_d;
      nen_q   <= nen_d;
      nmute_q <= nmute_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so
    // branches that do not assign it cannot infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rty_d   = rty_q;
    req_d   = req_q;
    reg_d   = reg_q;
    dat_d   = dat_q;
    nen_d   = nen_q;
    nmute_d = nmute_q;
    ready_d = ready_q;
    fault_d = fault_q;

    unique case (state_q)
      IDLE: begin
        if (ena) begin
          state_d = PWRUP;
          nen_d   = 1'b0;
          cnt_d   = EN_LOAD;
          idx_d   = '0;
          rty_d   = '0;
        end
      end

      PWRUP: begin
        if (!ena) begin
          state_d = SHDN;
        end else if (cnt_q == '0) begin
          state_d = WRITE;
          req_d   = 1'b1;
          reg_d   = tbl_reg;
          dat_d   = tbl_val;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // A started transaction is always allowed to finish, even on ena=0.
      WRITE: begin
        if (i2c.i2c_done) begin
          req_d = 1'b0;
          if (!ena) begin
            state_d = SHDN;
          end else if (!i2c.i2c_nack) begin
            if (idx_q == LAST_IDX) begin
              state_d = UNMUTE;
              cnt_d   = UM_LOAD;
            end else begin
              state_d = GAP;
              idx_d   = idx_q + 1'b1;
              rty_d   = '0;
            end
          end else if (rty_q < MAX_RTY) begin
            state_d = GAP;
            rty_d   = rty_q + 1'b1;
          end else begin
            state_d = FAULT;
            nen_d   = 1'b1;
            nmute_d = 1'b0;
            fault_d = 1'b1;
          end
        end
      end

      // tbl_idx has settled on the new index by now, so the ROM is valid.
      GAP: begin
        if (!ena) begin
          state_d = SHDN;
        end else begin
          state_d = WRITE;
          req_d   = 1'b1;
          reg_d   = tbl_reg;
          dat_d   = tbl_val;
        end
      end

      UNMUTE: begin
        if (!ena) begin
          state_d = SHDN;
        end else if (cnt_q == '0) begin
          state_d = RUN;
          nmute_d = ~soft_mute;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RUN: begin
        if (!ena) state_d = SHDN;
        else      nmute_d = ~soft_mute;
      end

      // Re-asserting ena here does not abort; IDLE restarts from idx 0.
      SHDN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          nen_d   = 1'b1;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      FAULT: begin
        if (!ena) begin
          state_d = IDLE;
          fault_d = 1'b0;
          idx_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    // Common SHDN entry actions, whichever state we came from.
    if (state_d == SHDN && state_q != SHDN) begin
      nmute_d = 1'b0;
      ready_d = 1'b0;
      req_d   = 1'b0;
      cnt_d   = UM_LOAD;
    end
  end

  assign tbl_idx     = idx_q;
  assign i2c.i2c_req = req_q;
  assign i2c.i2c_dev = DEV_ADDR;
  assign i2c.i2c_reg = reg_q;
  assign i2c.i2c_dat = dat_q;
  assign amp_nenable = nen_q;
  assign amp_nmute   = nmute_q;
  assign seq_ready   = ready_q;
  assign seq_fault   = fault_q;
  assign seq_state   = state_q;

endmodule

// File: tb/tb_amp_power_sequencer.sv
// ---------------------------------------------------------------------------
// tb_amp_power_sequencer
// Directed bench for amp_power_sequencer with N_REGS=3, T_EN_CYC=16,
// T_UNMUTE_CYC=8, RETRIES=2. A small I2C model answers each request with a
// done pulse 20 cycles after req rises and can NACK a chosen table index a
// chosen number of times. Outputs are sampled 1 time unit after posedge.
// ---------------------------------------------------------------------------
module tb_amp_power_sequencer;

  localparam int IW = 2;

  localparam logic [2:0] S_IDLE = 3'd0, S_PWRUP = 3'd1, S_WRITE = 3'd2,
                         S_GAP  = 3'd3, S_UNMUTE = 3'd4, S_RUN = 3'd5,
                         S_SHDN = 3'd6, S_FAULT = 3'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic          ena;
  logic          soft_mute;
  logic [IW-1:0] tbl_idx;
  logic [7:0]    tbl_reg;
  logic [7:0]    tbl_val;
  logic          amp_nenable;
  logic          amp_nmute;
  logic          seq_ready;
  logic          seq_fault;
  logic [2:0]    seq_state;

  amp_power_sequencer_if i2c_bus ();

  amp_power_sequencer #(
    .DEV_ADDR     (7'h2C),
    .N_REGS       (3),
    .T_EN_CYC     (16),
    .T_UNMUTE_CYC (8),
    .RETRIES      (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ena         (ena),
    .soft_mute   (soft_mute),
    .tbl_idx     (tbl_idx),
    .tbl_reg     (tbl_reg),
    .tbl_val     (tbl_val),
    .i2c         (i2c_bus),
    .amp_nenable (amp_nenable),
    .amp_nmute   (amp_nmute),
    .seq_ready   (seq_ready),
    .seq_fault   (seq_fault),
    .seq_state   (seq_state)
  );

  always #5 clk = ~clk;

  // Register table ROM.
  logic [7:0] rom_reg [3];
  logic [7:0] rom_val [3];
  initial begin
    rom_reg[0] = 8'h01; rom_val[0] = 8'hA5;
    rom_reg[1] = 8'h10; rom_val[1] = 8'h3C;
    rom_reg[2] = 8'h22; rom_val[2] = 8'h7F;
  end

  always_comb begin
    tbl_reg = 8'h00;
    tbl_val = 8'h00;
    if (tbl_idx < 2'd3) begin
      tbl_reg = rom_reg[tbl_idx];
      tbl_val = rom_val[tbl_idx];
    end
  end

  // I2C master model, driven on negedge.
  int nack_at   = -1;
  int nack_left = 0;
  int age       = 0;
  initial begin
    i2c_bus.i2c_done = 1'b0;
    i2c_bus.i2c_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || !i2c_bus.i2c_req || i2c_bus.i2c_done) begin
        age = 0;
        i2c_bus.i2c_done = 1'b0;
        i2c_bus.i2c_nack = 1'b0;
      end else begin
        age++;
        if (age == 20) begin
          i2c_bus.i2c_done = 1'b1;
          if (nack_left > 0 && int'(tbl_idx) == nack_at) begin
            i2c_bus.i2c_nack = 1'b1;
            nack_left--;
          end
        end
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Checks one write from req rising until req drops after done.
  task automatic expect_write(input int idx, input string tag);
    logic [7:0] r0, d0;
    int cycles, bad;
    check({tag, " req"}, 32'(i2c_bus.i2c_req), 32'd1);
    check({tag, " idx"}, 32'(tbl_idx), 32'(idx));
    check({tag, " reg"}, 32'(i2c_bus.i2c_reg), 32'(rom_reg[idx]));
    check({tag, " dat"}, 32'(i2c_bus.i2c_dat), 32'(rom_val[idx]));
    check({tag, " dev"}, 32'(i2c_bus.i2c_dev), 32'h2C);
    r0 = i2c_bus.i2c_reg;
    d0 = i2c_bus.i2c_dat;
    cycles = 0;
    bad = 0;
    while (cycles <= 40) begin
      tick(1);
      cycles++;
      if (!i2c_bus.i2c_req) break;
      if (i2c_bus.i2c_reg !== r0 || i2c_bus.i2c_dat !== d0) bad++;
    end
    check({tag, " req_len"}, 32'(cycles), 32'd20);
    check({tag, " held"}, 32'(bad), 32'd0);
  endtask

  task automatic gap_then_req(input int idx, input string tag);
    check({tag, " gap_state"}, 32'(seq_state), 32'(S_GAP));
    check({tag, " gap_idx"}, 32'(tbl_idx), 32'(idx));
    tick(1);
  endtask

  task automatic power_up_to_req(input string tag);
    ena = 1'b1;
    tick(1);
    check({tag, " pwrup"}, 32'(seq_state), 32'(S_PWRUP));
    check({tag, " nen_lo"}, 32'(amp_nenable), 32'd0);
    tick(15);
    check({tag, " no_req_yet"}, 32'(i2c_bus.i2c_req), 32'd0);
    tick(1);
  endtask

  task automatic unmute_to_run(input string tag);
    check({tag, " unmute"}, 32'(seq_state), 32'(S_UNMUTE));
    check({tag, " muted"}, 32'(amp_nmute), 32'd0);
    tick(7);
    check({tag, " not_ready"}, 32'(seq_ready), 32'd0);
    tick(1);
    check({tag, " run"}, 32'(seq_state), 32'(S_RUN));
    check({tag, " ready"}, 32'(seq_ready), 32'd1);
    check({tag, " nmute"}, 32'(amp_nmute), 32'd1);
    check({tag, " fault"}, 32'(seq_fault), 32'd0);
  endtask

  // Called just after the SHDN entry edge.
  task automatic shutdown_to_idle(input string tag);
    check({tag, " shdn"}, 32'(seq_state), 32'(S_SHDN));
    check({tag, " shdn_mute"}, 32'(amp_nmute), 32'd0);
    check({tag, " shdn_rdy"}, 32'(seq_ready), 32'd0);
    tick(7);
    check({tag, " nen_still_lo"}, 32'(amp_nenable), 32'd0);
    tick(1);
    check({tag, " nen_hi"}, 32'(amp_nenable), 32'd1);
    check({tag, " idle"}, 32'(seq_state), 32'(S_IDLE));
    check({tag, " idx0"}, 32'(tbl_idx), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " state"}, 32'(seq_state), 32'(S_IDLE));
    check({tag, " nen"}, 32'(amp_nenable), 32'd1);
    check({tag, " nmute"}, 32'(amp_nmute), 32'd0);
    check({tag, " req"}, 32'(i2c_bus.i2c_req), 32'd0);
    check({tag, " idx"}, 32'(tbl_idx), 32'd0);
    check({tag, " ready"}, 32'(seq_ready), 32'd0);
    check({tag, " fault"}, 32'(seq_fault), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    ena       = 1'b0;
    soft_mute = 1'b0;
    tick(3);
    check_reset_values("rst");
    reset = 1'b0;

    // Nominal power-up.
    power_up_to_req("up1");
    expect_write(0, "up1 w0");
    gap_then_req(1, "up1");
    expect_write(1, "up1 w1");
    gap_then_req(2, "up1");
    expect_write(2, "up1 w2");
    unmute_to_run("up1");

    // Soft mute in RUN.
    soft_mute = 1'b1;
    tick(1);
    check("smute on", 32'(amp_nmute), 32'd0);
    check("smute noreq", 32'(i2c_bus.i2c_req), 32'd0);
    soft_mute = 1'b0;
    tick(1);
    check("smute off", 32'(amp_nmute), 32'd1);
    check("smute run", 32'(seq_state), 32'(S_RUN));

    // Shutdown from RUN, then restart with a single NACK on idx 1.
    ena = 1'b0;
    tick(1);
    shutdown_to_idle("sd1");
    nack_at = 1; nack_left = 1;
    power_up_to_req("up2");
    expect_write(0, "up2 w0");
    gap_then_req(1, "up2");
    expect_write(1, "up2 w1n");
    gap_then_req(1, "up2 retry");
    expect_write(1, "up2 w1");
    gap_then_req(2, "up2");
    expect_write(2, "up2 w2");
    unmute_to_run("up2");

    // Three NACKs on idx 1 -> FAULT.
    ena = 1'b0;
    tick(1);
    shutdown_to_idle("sd2");
    nack_at = 1; nack_left = 3;
    power_up_to_req("up3");
    expect_write(0, "up3 w0");
    gap_then_req(1, "up3");
    expect_write(1, "up3 n1");
    gap_then_req(1, "up3 r1");
    expect_write(1, "up3 n2");
    gap_then_req(1, "up3 r2");
    expect_write(1, "up3 n3");
    check("fault state", 32'(seq_state), 32'(S_FAULT));
    check("fault flag", 32'(seq_fault), 32'd1);
    check("fault nen", 32'(amp_nenable), 32'd1);
    check("fault nmute", 32'(amp_nmute), 32'd0);
    tick(3);
    check("fault stays", 32'(seq_state), 32'(S_FAULT));
    check("fault noreq", 32'(i2c_bus.i2c_req), 32'd0);
    ena = 1'b0;
    tick(1);
    check("fault exit", 32'(seq_state), 32'(S_IDLE));
    check("fault clr", 32'(seq_fault), 32'd0);

    // ena dropped while the idx 2 write is pending.
    nack_left = 0;
    power_up_to_req("up4");
    expect_write(0, "up4 w0");
    gap_then_req(1, "up4");
    expect_write(1, "up4 w1");
    gap_then_req(2, "up4");
    ena = 1'b0;
    expect_write(2, "up4 w2 ena0");
    shutdown_to_idle("sd4");

    // Reset pulse in UNMUTE.
    power_up_to_req("up5");
    expect_write(0, "up5 w0");
    gap_then_req(1, "up5");
    expect_write(1, "up5 w1");
    gap_then_req(2, "up5");
    expect_write(2, "up5 w2");
    check("up5 unmute", 32'(seq_state), 32'(S_UNMUTE));
    tick(3);
    reset = 1'b1;
    tick(1);
    check_reset_values("mid rst");
    reset = 1'b0;
    ena   = 1'b0;
    tick(2);
    check("post rst idle", 32'(seq_state), 32'(S_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
